// File: rtl/serial_word_receiver.sv
// Serial-in, parallel-out receiver for start/data/stop framed bit streams.
// Reassembles WIDTH data bits (LSB- or MSB-first) into a valid/ready output register.
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             order_q;
  logic [WIDTH-1:0] shreg_q;
  logic             last_bit;
  logic             word_done;
  logic             stop_bad;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign busy     = (state_q != IDLE);

  // NOTE: every output of this block gets a default first so no path leaves a value held (no latch).
  always_comb begin
    state_d   = state_q;
    word_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      IDLE: if (sin_valid && !sin) state_d = DATA;
      DATA: if (sin_valid && last_bit) state_d = STOP;
      STOP: begin
        if (sin_valid) begin
          state_d   = IDLE;
          word_done = sin;
          stop_bad  = !sin;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the shift register is reset even though each frame overwrites it, so out can never show X.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      order_q <= 1'b0;
      shreg_q <= '0;
    end else if (sin_valid) begin
      case (state_q)
        IDLE: begin
          if (!sin) begin
            order_q <= lsb_first;
            cnt_q   <= '0;
          end
        end
        DATA: begin
          // LSB-first shifts right so the first bit ends up at bit 0.
          if (order_q) shreg_q <= {sin, shreg_q[WIDTH-1:1]};
          else         shreg_q <= {shreg_q[WIDTH-2:0], sin};
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (word_done) begin
        if (!out_valid || out_ready) begin
          out       <= shreg_q;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: directed scenarios plus randomized frames
// checked against a transaction-level model of the output register.
module tb_serial_word_receiver;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         sin;
  logic         sin_valid;
  logic         lsb_first;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  // Transaction-level model of what the consumer should see.
  logic [W-1:0] m_out;
  logic         m_valid;
  logic         m_overrun;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .sin_valid (sin_valid),
    .lsb_first (lsb_first),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sin_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_out = '0;
    m_valid = 1'b0;
    m_overrun = 1'b0;
  endtask

  // Sends one frame carrying 'word' in bit order 'order'; data bit i in time is
  // word[i] when LSB-first, word[W-1-i] when MSB-first. Updates the model afterwards.
  task automatic send_frame(input logic [W-1:0] word, input bit order, input bit good,
                            input bit ready, input int gmin, input int gmax,
                            input bit scramble, output int busy_cnt, output int exp_busy);
    int g;
    bit b;
    busy_cnt  = 0;
    exp_busy  = W + 1;
    out_ready = ready;
    lsb_first = order;
    sin       = 1'b0;
    sin_valid = 1'b1;
    tick();
    if (busy) busy_cnt++;
    if (ready) m_valid = 1'b0;
    if (scramble) lsb_first = ~order;
    for (int i = 0; i <= W; i++) begin
      g = int'($urandom_range(gmax, gmin));
      b = (i == W) ? good : (order ? word[i] : word[W-1-i]);
      repeat (g) begin
        sin_valid = 1'b0;
        sin = 1'($urandom_range(1, 0));
        tick();
        if (busy) busy_cnt++;
      end
      exp_busy += g;
      sin_valid = 1'b1;
      sin = b;
      tick();
      if (busy) busy_cnt++;
    end
    sin_valid = 1'b0;
    if (good) begin
      if (!m_valid || ready) begin
        m_out = word;
        m_valid = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    int idle_busy;
    do_reset();
    total++; if (out !== '0)       begin bad++; $display("FAIL reset_out got=%b want=%b", out, 4'b0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    idle_busy = 0;
    sin = 1'b1;
    sin_valid = 1'b1;
    repeat (3) begin
      tick();
      if (busy) idle_busy++;
    end
    sin_valid = 1'b0;
    total++; if (idle_busy != 0) begin bad++; $display("FAIL idle_line_busy got=%0d want=0", idle_busy); end
  endtask

  task automatic test_msb_first();
    int bc, eb;
    send_frame(4'b0101, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, bc, eb);
    total++; if (out !== 4'b0101)  begin bad++; $display("FAIL msb_out got=%b want=0101", out); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b want=1", out_valid); end
    total++; if (bc != 5)          begin bad++; $display("FAIL msb_busy_cycles got=%0d want=5", bc); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL msb_busy_end got=%b want=0", busy); end
    tick();
    m_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL msb_consume got=%b want=0", out_valid); end
    total++; if (out !== 4'b0101)  begin bad++; $display("FAIL msb_out_kept got=%b want=0101", out); end
  endtask

  task automatic test_lsb_first();
    int bc, eb;
    send_frame(4'b1010, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, bc, eb);
    total++; if (out !== 4'b1010)  begin bad++; $display("FAIL lsb_out got=%b want=1010", out); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid got=%b want=1", out_valid); end
    // Order captured as MSB-first, then lsb_first flips right after the start bit.
    send_frame(4'b1010, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, bc, eb);
    total++; if (out !== 4'b1010)  begin bad++; $display("FAIL order_hold_out got=%b want=1010", out); end
  endtask

  task automatic test_gaps();
    int bc, eb;
    send_frame(4'b1010, 1'b0, 1'b1, 1'b1, 3, 3, 1'b0, bc, eb);
    total++; if (out !== 4'b1010)  begin bad++; $display("FAIL gaps_out got=%b want=1010", out); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%b want=1", out_valid); end
    total++; if (bc != 20)         begin bad++; $display("FAIL gaps_busy_cycles got=%0d want=20", bc); end
  endtask

  task automatic test_frame_err();
    int bc, eb;
    send_frame(4'b1111, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, bc, eb);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_pulse got=%b want=1", frame_err); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ferr_valid got=%b want=0", out_valid); end
    total++; if (out !== 4'b1010)    begin bad++; $display("FAIL ferr_out_kept got=%b want=1010", out); end
    tick();
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_one_cycle got=%b want=0", frame_err); end
    send_frame(4'b0011, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, bc, eb);
    total++; if (out !== 4'b0011)    begin bad++; $display("FAIL ferr_next_out got=%b want=0011", out); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ferr_next_valid got=%b want=1", out_valid); end
  endtask

  task automatic test_overrun();
    int bc, eb;
    out_ready = 1'b1;
    tick();
    m_valid = 1'b0;
    send_frame(4'b0101, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, bc, eb);
    total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL ovr_first got=%b want=0", overrun); end
    send_frame(4'b1100, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, bc, eb);
    total++; if (out !== 4'b0101)    begin bad++; $display("FAIL ovr_out_kept got=%b want=0101", out); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", out_valid); end
    total++; if (overrun !== 1'b1)   begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
    out_ready = 1'b1;
    tick();
    m_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_consume got=%b want=0", out_valid); end
    tick();
    total++; if (overrun !== 1'b1)   begin bad++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_reset_midframe();
    int bc, eb;
    logic [W-1:0] w;
    lsb_first = 1'b0;
    sin_valid = 1'b1;
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    sin_valid = 1'b0;
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_out = '0; m_valid = 1'b0; m_overrun = 1'b0;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
    total++; if (out !== '0)         begin bad++; $display("FAIL mid_reset_out got=%b want=0000", out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want=0", out_valid); end
    total++; if (overrun !== 1'b0)   begin bad++; $display("FAIL mid_reset_overrun got=%b want=0", overrun); end
    w = W'($urandom);
    send_frame(w, 1'b1, 1'b1, 1'b1, 0, 1, 1'b0, bc, eb);
    total++; if (out !== w)          begin bad++; $display("FAIL mid_fresh_out got=%b want=%b", out, w); end
    total++; if (bc != eb)           begin bad++; $display("FAIL mid_fresh_busy got=%0d want=%0d", bc, eb); end
  endtask

  task automatic test_random();
    int bc, eb;
    logic [W-1:0] w;
    bit order, good, ready, scr;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      w     = W'($urandom);
      order = 1'($urandom_range(1, 0));
      good  = ($urandom_range(9, 0) != 0);
      ready = ($urandom_range(3, 0) != 0);
      scr   = 1'($urandom_range(1, 0));
      send_frame(w, order, good, ready, 0, 2, scr, bc, eb);
      total++; if (out !== m_out)         begin bad++; $display("FAIL rnd%0d_out got=%b want=%b", n, out, m_out); end
      total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd%0d_valid got=%b want=%b", n, out_valid, m_valid); end
      total++; if (overrun !== m_overrun) begin bad++; $display("FAIL rnd%0d_overrun got=%b want=%b", n, overrun, m_overrun); end
      total++; if (frame_err !== !good)   begin bad++; $display("FAIL rnd%0d_ferr got=%b want=%b", n, frame_err, !good); end
      total++; if (bc != eb)              begin bad++; $display("FAIL rnd%0d_busy got=%0d want=%0d", n, bc, eb); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    sin       = 1'b1;
    sin_valid = 1'b0;
    lsb_first = 1'b0;
    out_ready = 1'b1;
    m_out     = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gaps();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
